// File: rtl/Common.sv
// Common: project-wide scalar types
package Common;
  typedef logic [31:0] uint32;
endpackage

// File: rtl/MemoryBus.sv
// MemoryBus: data-memory command/result types plus load/store error codes and funct3 encodings
package MemoryBus;
  import Common::*;
  typedef struct packed {
    logic [3:0] mask_byte;
    uint32      write_data;
  } Cmd;
  typedef struct packed {
    uint32 read_data;
  } Result;
  typedef enum logic [1:0] {
    OK         = 2'b00,
    MISALIGNED = 2'b01,
    RANGE      = 2'b10,
    ILLEGAL    = 2'b11
  } LsuErr;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
endpackage

// File: rtl/load_extract.sv
// load_extract: picks the addressed byte/halfword from a read word and sign- or zero-extends it
module load_extract
  import Common::*, MemoryBus::*;
(
  input  uint32       i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_op,
  output uint32       o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_word[{i_off[1], 4'b0000} +: 16];
  assign o_data = i_op == F3_LB  ? {{24{w_byte[7]}}, w_byte}
                : i_op == F3_LH  ? {{16{w_half[15]}}, w_half}
                : i_op == F3_LBU ? {24'b0, w_byte}
                : i_op == F3_LHU ? {16'b0, w_half}
                : i_word;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store bus initiator; illegal accesses are rejected before any bus cycle
module load_store_unit
  import Common::*, MemoryBus::*;
#(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_addr,
  input  uint32            req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output uint32            rsp_rdata,
  output logic [1:0]       rsp_err,
  output logic [WIDTH-3:0] bus_address,
  output logic             write_enable,
  output Cmd               membuscmd,
  input  Result            membusres
);
  typedef enum logic [1:0] {IDLE, ACCESS, LOAD_DATA, RESP} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-3:0] r_addr;
  logic [1:0]       r_off;
  logic [2:0]       r_op;
  logic             r_store;
  uint32            r_wdata, r_rdata, w_wdata, w_ext;
  LsuErr            r_err, w_err;
  logic             w_accept, w_illegal, w_misaligned, w_range;
  logic [3:0]       w_mask;
  assign w_accept     = req_valid && req_ready;
  assign w_illegal    = req_store ? req_op >= 3'b011 : (req_op == 3'b011 || req_op[2:1] == 2'b11);
  assign w_misaligned = (req_op[1:0] == 2'b01 && req_addr[0]) || (req_op[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign w_range      = |req_addr[31:WIDTH];
  assign w_err        = w_illegal ? ILLEGAL : w_misaligned ? MISALIGNED : w_range ? RANGE : OK;
  assign w_wdata      = req_op == F3_SB ? {4{req_wdata[7:0]}} : req_op == F3_SH ? {2{req_wdata[15:0]}} : req_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    write_enable = 1'b0;
    w_mask       = 4'b0000;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (w_accept) w_next = w_err == OK ? ACCESS : RESP;
      end
      ACCESS: begin
        write_enable = r_store;
        w_mask       = !r_store ? 4'b0000 : r_op == F3_SB ? 4'b0001 << r_off : r_op == F3_SH ? 4'b0011 << r_off : 4'b1111;
        w_next       = r_store ? RESP : LOAD_DATA;
      end
      LOAD_DATA: w_next = RESP;
      default: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_addr  <= '0;
      r_off   <= 2'b00;
      r_op    <= 3'b000;
      r_store <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= OK;
    end else if (w_accept) begin
      r_err   <= w_err;
      r_rdata <= '0;
      if (w_err == OK) begin
        r_addr  <= req_addr[WIDTH-1:2];
        r_off   <= req_addr[1:0];
        r_op    <= req_op;
        r_store <= req_store;
        r_wdata <= w_wdata;
      end
    end else if (r_state == LOAD_DATA) r_rdata <= w_ext;
  load_extract u_extract (
    .i_word (membusres.read_data),
    .i_off  (r_off),
    .i_op   (r_op),
    .o_data (w_ext)
  );
  assign bus_address = r_addr;
  assign rsp_rdata   = r_rdata;
  assign rsp_err     = r_err;
  assign membuscmd   = '{mask_byte: w_mask, write_data: r_wdata};
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed requests checked every cycle against a byte-addressed reference model
module tb_load_store_unit;
  import Common::*;
  import MemoryBus::*;
  localparam int WIDTH = 15;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]   req_op = 3'b000;
  logic [31:0]  req_addr = '0;
  uint32        req_wdata = '0;
  logic         rsp_valid, rsp_ready = 1'b1;
  uint32        rsp_rdata;
  logic [1:0]   rsp_err;
  logic [WIDTH-3:0] bus_address;
  logic         write_enable;
  Cmd           membuscmd;
  Result        membusres = '0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  load_store_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_address(bus_address), .write_enable(write_enable),
    .membuscmd(membuscmd), .membusres(membusres)
  );
  // word-wide memory attached to the bus
  logic [31:0] bus_mem [8192] = '{default: 32'h0};
  logic [31:0] merged;
  always_comb begin
    merged = bus_mem[bus_address];
    for (int i = 0; i < 4; i++)
      if (membuscmd.mask_byte[i]) merged[8*i +: 8] = membuscmd.write_data[8*i +: 8];
  end
  always @(posedge clk) begin
    if (write_enable) bus_mem[bus_address] <= merged;
    membusres.read_data <= bus_mem[bus_address];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // reference model: byte memory and per-request expectations
  logic [7:0]  ref_mem [32768] = '{default: 8'h00};
  logic        m_pend = 1'b0, m_store = 1'b0, e_we, e_rv, legal;
  int          m_n = 0, m_lat = 1, m_size = 4, we_count = 0;
  logic [1:0]  m_err = 2'b00;
  logic [31:0] m_rdata = '0, m_addr = '0, m_wdata = '0, last_wdata = '0;
  logic [3:0]  last_mask = 4'b0;
  logic [31:0] last_baddr = '0;
  logic [63:0] v;
  initial forever begin
    @(negedge clk);
    if (!rst_n) m_pend = 1'b0;
    else begin
      e_we = m_pend && m_n == 0 && m_store && m_err == 2'b00;
      e_rv = m_pend && m_n >= m_lat - 1;
      chk("req_ready", 32'(req_ready), 32'(!m_pend));
      chk("write_enable", 32'(write_enable), 32'(e_we));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (!e_we) chk("mask_idle", 32'(membuscmd.mask_byte), 32'h0);
      if (e_rv) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end
      if (e_we) begin
        chk("bus_address", 32'(bus_address), m_addr >> 2);
        chk("mask_byte", 32'(membuscmd.mask_byte), 32'(((1 << m_size) - 1) << m_addr[1:0]));
        chk("write_data", membuscmd.write_data,
            m_size == 1 ? m_wdata[7:0] * 32'h01010101 : m_size == 2 ? m_wdata[15:0] * 32'h00010001 : m_wdata);
        last_mask = membuscmd.mask_byte;
        last_wdata = membuscmd.write_data;
        last_baddr = 32'(bus_address);
        we_count++;
        for (int i = 0; i < m_size; i++) ref_mem[m_addr + i] = 8'(m_wdata >> (8 * i));
      end
      if (m_pend) begin
        if (e_rv && rsp_ready) m_pend = 1'b0;
        else m_n++;
      end else if (req_valid) begin
        m_pend  = 1'b1;
        m_n     = 0;
        m_store = req_store;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        m_size  = (req_op == 3'd0 || req_op == 3'd4) ? 1 : (req_op == 3'd1 || req_op == 3'd5) ? 2 : 4;
        legal   = req_store ? req_op <= 3'd2 : (req_op <= 3'd2 || req_op == 3'd4 || req_op == 3'd5);
        m_err   = !legal ? 2'd3 : (req_addr % m_size != 0) ? 2'd1 : (req_addr >= (1 << WIDTH)) ? 2'd2 : 2'd0;
        m_lat   = m_err != 2'd0 ? 1 : m_store ? 2 : 3;
        v = '0;
        if (!m_store && m_err == 2'd0) begin
          for (int i = 0; i < m_size; i++) v = v | (64'(ref_mem[req_addr + i]) << (8 * i));
          if (req_op < 3'd4 && v[8*m_size-1]) v = v | (~64'd0 << (8 * m_size));
        end
        m_rdata = v[31:0];
      end
    end
  end
  task automatic wait_rsp(input string nm, output logic [31:0] rd, output logic [1:0] er);
    bit seen = 0;
    rd = '0;
    er = 2'b00;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        rd = rsp_rdata;
        er = rsp_err;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: rsp_valid=0 after 12 cycles, required 1", nm);
    end
  endtask
  task automatic req(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                     input string nm, output logic [31:0] rd, output logic [1:0] er);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_store = st;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(nm, rd, er);
  endtask
  logic [31:0] rd;
  logic [1:0]  er;
  int          hold;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #2;
    chk("rst req_ready", 32'(req_ready), 32'h1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst rsp_rdata", rsp_rdata, 32'h0);
    chk("rst rsp_err", 32'(rsp_err), 32'h0);
    chk("rst write_enable", 32'(write_enable), 32'h0);
    chk("rst mask", 32'(membuscmd.mask_byte), 32'h0);
    chk("rst write_data", membuscmd.write_data, 32'h0);
    chk("rst bus_address", 32'(bus_address), 32'h0);
    #21 rst_n = 1'b1;
    req(1, 3'b010, 32'h10, 32'hDEADBEEF, "SW10", rd, er);
    chk("SW10 bus_address", last_baddr, 32'h4);
    chk("SW10 mask", 32'(last_mask), 32'hF);
    req(0, 3'b010, 32'h10, 32'h0, "LW10", rd, er);
    chk("LW10 rdata", rd, 32'hDEADBEEF);
    req(1, 3'b000, 32'h13, 32'h000000A5, "SB13", rd, er);
    chk("SB13 mask", 32'(last_mask), 32'h8);
    chk("SB13 wdata", last_wdata, 32'hA5A5A5A5);
    req(0, 3'b000, 32'h13, 32'h0, "LB13", rd, er);
    chk("LB13 rdata", rd, 32'hFFFFFFA5);
    req(0, 3'b100, 32'h13, 32'h0, "LBU13", rd, er);
    chk("LBU13 rdata", rd, 32'h000000A5);
    req(1, 3'b010, 32'h14, 32'h12345678, "SW14", rd, er);
    req(1, 3'b001, 32'h16, 32'h00008001, "SH16", rd, er);
    chk("SH16 mask", 32'(last_mask), 32'hC);
    req(0, 3'b001, 32'h16, 32'h0, "LH16", rd, er);
    chk("LH16 rdata", rd, 32'hFFFF8001);
    req(0, 3'b101, 32'h16, 32'h0, "LHU16", rd, er);
    chk("LHU16 rdata", rd, 32'h00008001);
    req(0, 3'b010, 32'h14, 32'h0, "LW14", rd, er);
    chk("LW14 rdata", rd, 32'h80015678);
    req(0, 3'b010, 32'h12, 32'h0, "LW12", rd, er);
    chk("LW12 err", 32'(er), 32'h1);
    req(1, 3'b001, 32'h11, 32'h1234, "SH11", rd, er);
    chk("SH11 err", 32'(er), 32'h1);
    req(0, 3'b010, 32'h8000, 32'h0, "LW8000", rd, er);
    chk("LW8000 err", 32'(er), 32'h2);
    req(1, 3'b011, 32'h10, 32'h0, "ST011", rd, er);
    chk("ST011 err", 32'(er), 32'h3);
    req(0, 3'b110, 32'h10, 32'h0, "LD110", rd, er);
    chk("LD110 err", 32'(er), 32'h3);
    // backpressure with a competing request that must be ignored
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_store = 1'b0;
    req_op    = 3'b010;
    req_addr  = 32'h14;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp("LW14 hold", rd, er);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_store = 1'b1;
    req_addr  = 32'h14;
    req_wdata = 32'h0;
    hold = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid && rsp_rdata == 32'h80015678 && !req_ready) hold++;
    end
    chk("hold cycles", 32'(hold), 32'd5);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    req(0, 3'b010, 32'h14, 32'h0, "LW14 after hold", rd, er);
    chk("LW14 after hold", rd, 32'h80015678);
    // reset during the ACCESS cycle of a store
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_store = 1'b1;
    req_op    = 3'b010;
    req_addr  = 32'h20;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("we before reset", 32'(write_enable), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("we async drop", 32'(write_enable), 32'h0);
    chk("ready in reset", 32'(req_ready), 32'h1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no rsp after abort", 32'(rsp_valid), 32'h0);
    req(0, 3'b010, 32'h20, 32'h0, "LW20", rd, er);
    chk("LW20 rdata", rd, 32'h0);
    chk("we pulses", 32'(we_count), 32'd4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Bus initiator for the data memory: accepts one load or store request at a time from the CPU execute stage and drives the `MemoryBus` command side (word address, per-byte write mask, lane-replicated write data, write enable). On the result side it captures read data, extracts the addressed byte or halfword, and sign- or zero-extends it. Alignment and range checks run before any bus activity, so an illegal access never reaches the memory.

## Interface

- `WIDTH`, 15, byte-address width of data memory; word address is `WIDTH-2` bits
- `clk` in 1: clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted when `req_valid && req_ready`
- `req_store` in 1: 1 = store, 0 = load
- `req_op` in 3: funct3 encoding
  - loads: LB 000, LH 001, LW 010, LBU 100, LHU 101
  - stores: SB 000, SH 001, SW 010
- `req_addr` in 32: byte address
- `req_wdata` in 32: store data, right-justified
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`
- `rsp_rdata` out 32: extended load data; 0 for stores and errors
- `rsp_err` out 2: 00 ok, 01 misaligned, 10 out of range, 11 illegal op
- `bus_address` out WIDTH-2: word address to memory
- `write_enable` out 1: store strobe
- `membuscmd` out `MemoryBus::Cmd`: `mask_byte`, `write_data`
- `membusres` in `MemoryBus::Result`: 32-bit read word, valid the cycle after the address edge

## Operation

- FSM states: IDLE, ACCESS, LOAD_DATA, RESP.
- `req_ready` = (state == IDLE). Requests presented in any other state are ignored.
- On accept, checks run in priority order:
  1. illegal op: store with op ≥ 011; load op 011, 110 or 111
  2. misaligned: halfword with `addr[0]`=1; word with `addr[1:0]`≠0
  3. out of range: `addr[31:WIDTH]`≠0
- Check result on accept:
  - Any error: go to RESP with `rsp_err` set and `rsp_rdata`=0. No bus cycle.
  - No error: register `bus_address`=`addr[WIDTH-1:2]`, offset `addr[1:0]`, op and data; go to ACCESS.
- ACCESS, one cycle:
  - `write_enable`=`req_store`
  - `mask_byte`: SB = 1<<off; SH = 0011<<off; SW = 1111; loads = 0000
  - `write_data`: SB = byte ×4; SH = halfword ×2; SW = word
  - Next state: store → RESP; load → LOAD_DATA.
- LOAD_DATA: sub-module selects lane(s) from `membusres` by offset, extends (LB/LH sign, LBU/LHU zero, LW as-is), and registers the result into `rsp_rdata`. Go to RESP.
- RESP: hold `rsp_valid`=1 and the data/err fields stable until `rsp_ready`, then go to IDLE.
- Outside ACCESS: `write_enable`=0 and `mask_byte`=0. `bus_address` holds its last value.

## Timing

- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=00, `write_enable`=0, `mask_byte`=0, `write_data`=0, `bus_address`=0.
- Accept→`rsp_valid` latency, with accept edge E0:
  - load: 3 edges; memory reads at E1, data registered at E2, `rsp_valid` high after E2
  - store: 2 edges; memory writes at E1
  - error: 1 edge
- `write_enable` is exactly a one-cycle pulse per store.
- Throughput: back-to-back requests are not accepted; next accept is no earlier than the cycle after RESP handshake.
- `rsp_ready` may be tied high; `rsp_valid` is then a one-cycle pulse.
- `rst_n` low in any state: immediate return to reset values, including mid-ACCESS (`write_enable` drops asynchronously). No response is produced for the aborted request.

## Structure

- Add to the shared `MemoryBus` package:
  - `LsuErr` enum (OK, MISALIGNED, RANGE, ILLEGAL)
  - funct3 localparams for the load/store ops
- Reuse `uint32` from `Common`.
- One combinational sub-module, `load_extract`: inputs are the word, offset and op; output is the extended 32-bit value. It is reusable by a future cache.

## Test plan

- SW 0x10 / 0xDEADBEEF → one `write_enable` pulse, `bus_address`=4, mask 1111; then LW 0x10 → `rsp_rdata`=0xDEADBEEF with `rsp_valid` high 3 edges after accept.
- SB 0x13 / 0x000000A5 → mask 1000, `write_data`=0xA5A5A5A5; then LB 0x13 → 0xFFFFFFA5, and LBU 0x13 → 0x000000A5.
- SH 0x16 / 0x8001 after SW 0x14 / 0x12345678 → mask 1100; LH 0x16 → 0xFFFF8001; LW 0x14 → 0x80015678.
- Error cases, each → `rsp_valid` one edge after accept and no `write_enable`:
  - LW 0x12 → err 01
  - SH 0x11 → err 01
  - LW 0x8000 (WIDTH=15) → err 10
  - store op 011 → err 11
- `rsp_ready` low for 5 cycles → `rsp_valid`/`rsp_rdata` stable, `req_ready`=0, and a competing request is not accepted.
- `rst_n` asserted during ACCESS of SW → `write_enable` low immediately, memory unchanged on readback, no `rsp_valid`.
